// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port: in-order FIFO,
// registered write stage, per-register pending scoreboard and newest-value forwarding.
module regfile_wb_queue #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_wn,
    input  logic [DW-1:0]            in_d,
    input  logic                     rf_hold,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wn,
    output logic [DW-1:0]            rf_d,
    output logic [2**AW-1:0]         busy,
    input  logic [AW-1:0]            fwd_rn,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_d,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int PCW = $clog2(DEPTH + 2);
    localparam int NR  = 2**AW;

    // Handshake: a result transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered occupancy, never on in_valid.

    logic [AW-1:0]  r_wn_mem [DEPTH];
    logic [DW-1:0]  r_d_mem  [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_rf_we;
    logic [AW-1:0]  r_rf_wn;
    logic [DW-1:0]  r_rf_d;
    logic [PCW-1:0] r_pc [NR];

    logic           w_push;
    logic           w_pop;
    logic           w_fwd_hit;
    logic [DW-1:0]  w_fwd_d;
    logic [NR-1:0]  w_busy;

    assign w_push = in_valid && (r_count != CW'(DEPTH));
    assign w_pop  = (r_count != '0) && !rf_hold;

    assign in_ready = (r_count != CW'(DEPTH));
    assign count    = r_count;
    assign rf_we    = r_rf_we;
    assign rf_wn    = r_rf_wn;
    assign rf_d     = r_rf_d;
    assign busy     = w_busy;
    assign fwd_hit  = w_fwd_hit;
    assign fwd_d    = w_fwd_d;

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_wn_mem[i] <= '0;
                r_d_mem[i]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wn_mem[r_wr_ptr] <= in_wn;
                r_d_mem[r_wr_ptr]  <= in_d;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: the register file samples these on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we <= 1'b0;
            r_rf_wn <= '0;
            r_rf_d  <= '0;
        end else if (w_pop) begin
            r_rf_we <= 1'b1;
            r_rf_wn <= r_wn_mem[r_rd_ptr];
            r_rf_d  <= r_d_mem[r_rd_ptr];
        end else begin
            r_rf_we <= 1'b0;
        end
    end

    // A write retires on the edge after it was presented with rf_we=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                r_pc[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                if ((w_push && in_wn == AW'(r)) && !(r_rf_we && r_rf_wn == AW'(r))) begin
                    r_pc[r] <= r_pc[r] + 1'b1;
                end else if (!(w_push && in_wn == AW'(r)) && (r_rf_we && r_rf_wn == AW'(r))) begin
                    r_pc[r] <= r_pc[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int r = 0; r < NR; r++) begin
            w_busy[r] = (r_pc[r] != '0);
        end
    end

    // Scan oldest to newest so the newest matching entry overrides older ones;
    // the output stage is older than anything still in the FIFO.
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_d   = '0;
        if (r_rf_we && r_rf_wn == fwd_rn) begin
            w_fwd_hit = 1'b1;
            w_fwd_d   = r_rf_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_wn_mem[r_rd_ptr + PW'(i)] == fwd_rn)) begin
                w_fwd_hit = 1'b1;
                w_fwd_d   = r_d_mem[r_rd_ptr + PW'(i)];
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));

endmodule
